// File: rtl/fp32_mult_pkg.sv
// ---------------------------------------------------------------------------
// fp32_mult_pkg
// Shared constants and types for the FP32 multiplier normalise/round stage.
//   EXP_BIAS / QNAN / EXP_MAX : IEEE-754 single constants
//   FLAG_*                    : bit positions in the 4-bit status flag vector
//   EXC_*                     : bit positions in the 5-bit input-exception vector
//   stage1_t                  : contents of the stage-1 pipeline register
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package fp32_mult_pkg;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    // Status flag layout {NV, OF, UF, NX}
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Input exception layout {any, ANaN, BNaN, AInf, BInf}
    localparam int EXC_ANY  = 4;
    localparam int EXC_ANAN = 3;
    localparam int EXC_BNAN = 2;
    localparam int EXC_AINF = 1;
    localparam int EXC_BINF = 0;

    // Stage-1 register: sign, zero detects, exceptions, unrounded exponent
    // (10-bit signed so both underflow and overflow stay representable),
    // 23-bit mantissa plus guard and sticky bits.
    typedef struct packed {
        logic              sign;
        logic              za;
        logic              zb;
        logic [4:0]        exc;
        logic signed [9:0] exp;
        logic [22:0]       man;
        logic              g;
        logic              s;
    } stage1_t;

endpackage

// File: rtl/fp32_mult_norm_round_round.sv
// ---------------------------------------------------------------------------
// fp32_round
// Combinational rounding of a normalised 23-bit mantissa.
//   i_man, i_g, i_s : mantissa, guard bit, sticky bit
//   i_exp           : unrounded signed exponent
//   o_man, o_exp    : rounded mantissa / exponent (carry-out bumps exponent)
//   o_inexact       : guard | sticky
// Build option: define FP_MULT_RNE_EN for round-to-nearest-even; otherwise
// the mantissa is truncated (round toward zero).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fp32_round
    import fp32_mult_pkg::*;
(
    input  logic [22:0]       i_man,
    input  logic              i_g,
    input  logic              i_s,
    input  logic signed [9:0] i_exp,
    output logic [22:0]       o_man,
    output logic signed [9:0] o_exp,
    output logic              o_inexact
);

    logic        w_inc;
    logic [23:0] w_sum;

    // Increment decision: ties go to the even mantissa in RNE; truncation
    // never increments.
`ifdef FP_MULT_RNE_EN
    assign w_inc = i_g & (i_s | i_man[0]);
`else
    assign w_inc = 1'b0;
`endif

    assign w_sum = {1'b0, i_man} + {23'd0, w_inc};

    // A carry out of the mantissa means 1.111..1 rounded up to 10.0, so the
    // fraction becomes zero and the exponent moves up by one.
    always_comb begin
        o_man     = w_sum[22:0];
        o_exp     = i_exp;
        o_inexact = i_g | i_s;
        if (w_sum[23]) begin
            o_man = 23'd0;
            o_exp = i_exp + 10'sd1;
        end
    end

endmodule

// File: rtl/fp32_mult_norm_round.sv
// ---------------------------------------------------------------------------
// fp32_mult_norm_round
// Downstream stage of the FP32 multiplier: forms the result exponent,
// normalises the 48-bit mantissa product, rounds and applies the
// exception / overflow / underflow overrides. Two-stage valid/ready pipeline.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake
//   Sa, Sb, Ea, Eb      : operand signs and biased exponents
//   Mp                  : mantissa product, leading one at bit 47 or 46
//   InputExc            : {any, ANaN, BNaN, AInf, BInf}
//   out_valid, out_ready: output handshake
//   P, flags            : packed FP32 result, {NV, OF, UF, NX}
// Build option: FP_MULT_RNE_EN selects round-to-nearest-even (default is
// round toward zero); latency and handshake are the same in both builds.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fp32_mult_norm_round
    import fp32_mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        Sa,
    input  logic        Sb,
    input  logic [7:0]  Ea,
    input  logic [7:0]  Eb,
    input  logic [47:0] Mp,
    input  logic [4:0]  InputExc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] P,
    output logic [3:0]  flags
);

    logic              r_s1Valid;
    stage1_t           r_s1;
    logic              r_outValid;
    logic [31:0]       r_P;
    logic [3:0]        r_flags;

    logic              w_s2Take;
    logic              w_inReady;
    stage1_t           w_s1Next;
    logic [9:0]        w_expSum;
    logic [22:0]       w_manRnd;
    logic signed [9:0] w_expRnd;
    logic              w_inexact;
    logic              w_excAny;
    logic              w_nanIn;
    logic              w_infIn;
    logic              w_infTimesZero;
    logic [31:0]       w_P;
    logic [3:0]        w_flags;

    // Output register frees up when empty or being read; stage 1 frees up
    // when empty or when its contents move into the output register.
    assign w_s2Take  = ~r_outValid | out_ready;
    assign w_inReady = ~r_s1Valid | w_s2Take;
    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign P         = r_P;
    assign flags     = r_flags;

    // Stage-1 datapath: sign, zero flush, exponent and normalisation.
    // The exponent sum is done in 10 bits; two's complement wrap gives the
    // correct signed result for negative (underflowing) exponents.
    always_comb begin
        w_s1Next      = '0;
        w_s1Next.sign = Sa ^ Sb;
        w_s1Next.za   = (Ea == 8'd0);
        w_s1Next.zb   = (Eb == 8'd0);
        w_s1Next.exc  = InputExc;
        w_expSum      = {2'b00, Ea} + {2'b00, Eb} + {9'd0, Mp[47]} - 10'(EXP_BIAS);
        w_s1Next.exp  = signed'(w_expSum);
        if (Mp[47]) begin
            w_s1Next.man = Mp[46:24];
            w_s1Next.g   = Mp[23];
            w_s1Next.s   = |Mp[22:0];
        end else begin
            w_s1Next.man = Mp[45:23];
            w_s1Next.g   = Mp[22];
            w_s1Next.s   = |Mp[21:0];
        end
    end

    // Stage-1 register: the valid bit follows in_valid whenever the stage
    // can load; data is only captured on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1      <= '0;
        end else if (w_inReady) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1 <= w_s1Next;
            end
        end
    end

    fp32_round u_round (
        .i_man     (r_s1.man),
        .i_g       (r_s1.g),
        .i_s       (r_s1.s),
        .i_exp     (r_s1.exp),
        .o_man     (w_manRnd),
        .o_exp     (w_expRnd),
        .o_inexact (w_inexact)
    );

    // The "any" summary bit is implied by every individual exception bit, so
    // qualifying with it does not change the selected result.
    assign w_excAny       = r_s1.exc[EXC_ANY] | (|r_s1.exc[EXC_ANAN:EXC_BINF]);
    assign w_nanIn        = r_s1.exc[EXC_ANAN] | r_s1.exc[EXC_BNAN];
    assign w_infIn        = r_s1.exc[EXC_AINF] | r_s1.exc[EXC_BINF];
    assign w_infTimesZero = (r_s1.exc[EXC_AINF] & r_s1.zb) | (r_s1.exc[EXC_BINF] & r_s1.za);

    // Result selection in priority order: invalid, infinity, zero operand,
    // overflow, underflow, normal. Flags not set by a case stay zero.
    always_comb begin
        w_P     = '0;
        w_flags = '0;
        if (w_excAny && (w_nanIn || w_infTimesZero)) begin
            w_P              = QNAN;
            w_flags[FLAG_NV] = 1'b1;
        end else if (w_excAny && w_infIn) begin
            w_P = {r_s1.sign, EXP_MAX, 23'h0};
        end else if (r_s1.za || r_s1.zb) begin
            w_P = {r_s1.sign, 31'h0};
        end else if (w_expRnd >= 10'sd255) begin
            w_P              = {r_s1.sign, EXP_MAX, 23'h0};
            w_flags[FLAG_OF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
        end else if (w_expRnd <= 10'sd0) begin
            w_P              = {r_s1.sign, 31'h0};
            w_flags[FLAG_UF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
        end else begin
            w_P              = {r_s1.sign, w_expRnd[7:0], w_manRnd};
            w_flags[FLAG_NX] = w_inexact;
        end
    end

    // Output register: holds P/flags steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_P        <= '0;
            r_flags    <= '0;
        end else if (w_s2Take) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_P     <= w_P;
                r_flags <= w_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp32_mult_norm_round.sv
// ---------------------------------------------------------------------------
// tb_fp32_mult_norm_round
// Directed self-checking bench for fp32_mult_norm_round. Expected results
// are queued when an input transfer happens and compared when the DUT hands
// a result over. Honours FP_MULT_RNE_EN for the rounding-dependent case.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fp32_mult_norm_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        Sa;
    logic        Sb;
    logic [7:0]  Ea;
    logic [7:0]  Eb;
    logic [47:0] Mp;
    logic [4:0]  InputExc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] P;
    logic [3:0]  flags;

    typedef struct packed {
        logic [31:0] p;
        logic [3:0]  f;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    int checks   = 0;
    int errors   = 0;
    int outCount = 0;
    int baseCount;
    logic [31:0] expTie2;

    fp32_mult_norm_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sa        (Sa),
        .Sb        (Sb),
        .Ea        (Ea),
        .Eb        (Eb),
        .Mp        (Mp),
        .InputExc  (InputExc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .flags     (flags)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts the check, reports and counts failures
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one input and hold it until accepted; the expected result is
    // queued on the cycle the transfer happens.
    task automatic applyStimulus(input logic sa, input logic sb, input logic [7:0] ea,
                                 input logic [7:0] eb, input logic [47:0] mp,
                                 input logic [4:0] exc, input logic [31:0] expP,
                                 input logic [3:0] expF);
        logic accepted;
        sbEntry_t e;
        accepted = 1'b0;
        Sa = sa; Sb = sb; Ea = ea; Eb = eb; Mp = mp; InputExc = exc;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.p = expP;
                e.f = expF;
                sbQ.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        checkOutput("input_accepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every queued result has come out
    task automatic waitDrain();
        for (int i = 0; i < 30; i++) begin
            if (sbQ.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    endtask

    // Output monitor: on every cycle where a result is handed over, compare
    // it with the oldest queued expectation.
    always @(negedge clk) begin
        sbEntry_t e;
        if (rst_n && out_valid && out_ready) begin
            outCount++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_output_queue_size", 32'(sbQ.size()), 32'd1);
            end else begin
                e = sbQ.pop_front();
                checkOutput($sformatf("result%0d_P", outCount), P, e.p);
                checkOutput($sformatf("result%0d_flags", outCount), {28'd0, flags}, {28'd0, e.f});
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence
    initial begin
`ifdef FP_MULT_RNE_EN
        expTie2 = 32'h3F80_0002;
`else
        expTie2 = 32'h3F80_0001;
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Sa = 1'b0; Sb = 1'b0; Ea = 8'd0; Eb = 8'd0; Mp = 48'd0; InputExc = 5'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_P", P, 32'd0);
        checkOutput("reset_flags", {28'd0, flags}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // 1.5 x 2.0 with latency check
        $display("[TB] basic multiply and latency");
        applyStimulus(1'b0, 1'b0, 8'd127, 8'd128, 48'h6000_0000_0000, 5'b00000, 32'h4040_0000, 4'b0000);
        idle();
        checkOutput("latency_edge1_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency_edge2_out_valid", {31'd0, out_valid}, 32'd1);
        waitDrain();

        // Rounding, overflow, underflow, exceptions streamed back to back
        $display("[TB] rounding, range and exception cases");
        applyStimulus(1'b0, 1'b0, 8'd127, 8'd127, 48'h4000_0040_0000, 5'b00000, 32'h3F80_0000, 4'b0001);
        applyStimulus(1'b0, 1'b0, 8'd127, 8'd127, 48'h4000_00C0_0000, 5'b00000, expTie2, 4'b0001);
        applyStimulus(1'b1, 1'b0, 8'd254, 8'd254, 48'h4000_0000_0000, 5'b00000, 32'hFF80_0000, 4'b0101);
        applyStimulus(1'b0, 1'b0, 8'd1, 8'd1, 48'h4000_0000_0000, 5'b00000, 32'h0000_0000, 4'b0011);
        applyStimulus(1'b0, 1'b0, 8'd255, 8'd127, 48'h4000_0000_0000, 5'b11000, 32'h7FC0_0000, 4'b1000);
        applyStimulus(1'b0, 1'b0, 8'd255, 8'd0, 48'h4000_0000_0000, 5'b10010, 32'h7FC0_0000, 4'b1000);
        applyStimulus(1'b0, 1'b1, 8'd255, 8'd128, 48'h4000_0000_0000, 5'b10010, 32'hFF80_0000, 4'b0000);
        applyStimulus(1'b1, 1'b1, 8'd0, 8'd130, 48'h4000_0000_0000, 5'b00000, 32'h0000_0000, 4'b0000);
        idle();
        waitDrain();

        // Backpressure: two accepted, then stall with output held
        $display("[TB] backpressure");
        baseCount = outCount;
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd127, 8'd128, 48'h6000_0000_0000, 5'b00000, 32'h4040_0000, 4'b0000);
        applyStimulus(1'b0, 1'b0, 8'd128, 8'd127, 48'h4000_0000_0000, 5'b00000, 32'h4000_0000, 4'b0000);
        Sa = 1'b1; Sb = 1'b0; Ea = 8'd127; Eb = 8'd127; Mp = 48'h4000_0000_0000; InputExc = 5'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
            checkOutput($sformatf("stall%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("stall%0d_P_hold", i), P, 32'h4040_0000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd127, 8'd127, 48'h4000_0000_0000, 5'b00000, 32'hBF80_0000, 4'b0000);
        applyStimulus(1'b0, 1'b0, 8'd126, 8'd127, 48'h4000_0000_0000, 5'b00000, 32'h3F00_0000, 4'b0000);
        idle();
        waitDrain();
        checkOutput("backpressure_result_count", 32'(outCount - baseCount), 32'd4);

        // Reset with two results in flight
        $display("[TB] reset mid-flight");
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd127, 8'd128, 48'h6000_0000_0000, 5'b00000, 32'h4040_0000, 4'b0000);
        applyStimulus(1'b0, 1'b0, 8'd128, 8'd127, 48'h4000_0000_0000, 5'b00000, 32'h4000_0000, 4'b0000);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_reset_P", P, 32'd0);
        checkOutput("async_reset_flags", {28'd0, flags}, 32'd0);
        sbQ.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held_reset_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        baseCount = outCount;
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 1'b1, 8'd129, 8'd127, 48'h6000_0000_0000, 5'b00000, 32'h40C0_0000, 4'b0000);
        idle();
        checkOutput("post_reset_edge1_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("post_reset_edge2_out_valid", {31'd0, out_valid}, 32'd1);
        waitDrain();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_reset_result_count", 32'(outCount - baseCount), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
